nios_onchip_mem_arbiter: RTL and testbench

Two-requester arbiter for the 4-word × 32-bit single-port on-chip RAM in the Nios subsystem. It shares the RAM between the Nios data master (requester 0) and the NES-side hardware master (requester 1). Requesters use Avalon-MM with waitrequest and readdatavalid. The block drives the RAM's address/byteenable/chipselect/write/writedata/clken pins and returns read data with a fixed one-cycle latency. Arbitration is round-robin; a freeze input stalls the shared port.

---
 rtl/nios_onchip_mem_arbiter_pkg.sv | 17 +
 rtl/nios_onchip_mem_arbiter_if.sv | 33 +++
 rtl/nios_onchip_mem_arbiter_rr_arb2.sv | 21 ++
 rtl/nios_onchip_mem_arbiter.sv | 83 ++++++++
 tb/tb_nios_onchip_mem_arbiter.sv | 269 ++++++++++++++++++++++++++
 5 files changed

// File: rtl/nios_onchip_mem_arbiter_pkg.sv
// Shared types and widths for the Nios on-chip RAM arbiter.
package nios_memarb_pkg;
  localparam int ADDR_W  = 2;
  localparam int DATA_W  = 32;
  localparam int BE_W    = DATA_W / 8;
  localparam int NUM_REQ = 2;

  typedef struct packed {
    logic [ADDR_W-1:0] address;
    logic [BE_W-1:0]   byteenable;
    logic              read;
    logic              write;
    logic [DATA_W-1:0] writedata;
  } req_t;

  typedef enum logic [1:0] {GNT_NONE, GNT_M0, GNT_M1} grant_t;
endpackage

// File: rtl/nios_onchip_mem_arbiter_if.sv
// Avalon-MM requester bundle and single-port RAM bundle used by the arbiter.
interface nios_memarb_avm_if;
  import nios_memarb_pkg::*;
  logic [ADDR_W-1:0] address;
  logic [BE_W-1:0]   byteenable;
  logic              read;
  logic              write;
  logic [DATA_W-1:0] writedata;
  logic              waitrequest;
  logic [DATA_W-1:0] readdata;
  logic              readdatavalid;

  modport master (output address, byteenable, read, write, writedata,
                  input  waitrequest, readdata, readdatavalid);
  modport slave  (input  address, byteenable, read, write, writedata,
                  output waitrequest, readdata, readdatavalid);
endinterface

interface nios_memarb_mem_if;
  import nios_memarb_pkg::*;
  logic [ADDR_W-1:0] address;
  logic [BE_W-1:0]   byteenable;
  logic              chipselect;
  logic              write;
  logic [DATA_W-1:0] writedata;
  logic              clken;
  logic [DATA_W-1:0] readdata;

  modport master (output address, byteenable, chipselect, write, writedata, clken,
                  input  readdata);
  modport slave  (input  address, byteenable, chipselect, write, writedata, clken,
                  output readdata);
endinterface

// File: rtl/nios_onchip_mem_arbiter_rr_arb2.sv
// Two-way round-robin grant: on contention the requester that did not win last time wins.
module rr_arb2
  import nios_memarb_pkg::*;
(
  input  logic [NUM_REQ-1:0] req_i,
  input  logic               last_grant_i,
  input  logic               enable_i,
  output grant_t             grant_o
);
  always_comb begin
    grant_o = GNT_NONE;
    if (enable_i) begin
      case (req_i)
        2'b01:   grant_o = GNT_M0;
        2'b10:   grant_o = GNT_M1;
        2'b11:   grant_o = last_grant_i ? GNT_M0 : GNT_M1;
        default: grant_o = GNT_NONE;
      endcase
    end
  end
endmodule

// File: rtl/nios_onchip_mem_arbiter.sv
// Shares the 4x32 single-port on-chip RAM between the Nios data master and the NES master.
module nios_onchip_mem_arbiter
  import nios_memarb_pkg::*;
(
  input  logic              clk,
  input  logic              reset,
  input  logic              freeze,
  nios_memarb_avm_if.slave  m0,
  nios_memarb_avm_if.slave  m1,
  nios_memarb_mem_if.master mem
);
  req_t [NUM_REQ-1:0] req;
  logic [NUM_REQ-1:0] active;
  grant_t             gnt;
  logic               gnt_vld, sel;
  req_t               sreq;
  logic               last_grant_q, last_grant_d;
  logic               rd_pend_q, rd_pend_d;
  logic               rd_owner_q, rd_owner_d;
  logic               rd_ok;

  assign req[0] = {m0.address, m0.byteenable, m0.read, m0.write, m0.writedata};
  assign req[1] = {m1.address, m1.byteenable, m1.read, m1.write, m1.writedata};

  for (genvar n = 0; n < NUM_REQ; n++) begin : g_act
    assign active[n] = req[n].read | req[n].write;
  end

  rr_arb2 u_arb (
    .req_i        (active),
    .last_grant_i (last_grant_q),
    .enable_i     (~freeze & ~reset),
    .grant_o      (gnt)
  );

  assign gnt_vld = (gnt != GNT_NONE);
  assign sel     = (gnt == GNT_M1);
  // Idle selects requester 0 so the RAM pins never float to X.
  assign sreq    = req[sel];

  assign mem.address    = sreq.address;
  assign mem.byteenable = sreq.byteenable;
  assign mem.writedata  = sreq.writedata;
  assign mem.chipselect = gnt_vld;
  assign mem.write      = gnt_vld & sreq.write;
  assign mem.clken      = reset | ~freeze;

  assign m0.waitrequest = (gnt != GNT_M0);
  assign m1.waitrequest = (gnt != GNT_M1);
  assign m0.readdata    = mem.readdata;
  assign m1.readdata    = mem.readdata;

  // A pending response stays hidden while frozen (RAM q is held) and dies with reset.
  assign rd_ok            = rd_pend_q & ~freeze & ~reset;
  assign m0.readdatavalid = rd_ok & ~rd_owner_q;
  assign m1.readdatavalid = rd_ok &  rd_owner_q;

  always_comb begin
    last_grant_d = last_grant_q;
    rd_pend_d    = rd_pend_q;
    rd_owner_d   = rd_owner_q;
    if (!freeze) begin
      // Write wins over a simultaneous read: no response is owed.
      rd_pend_d = gnt_vld & sreq.read & ~sreq.write;
      if (gnt_vld) begin
        last_grant_d = sel;
        rd_owner_d   = sel;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      last_grant_q <= 1'b1;
      rd_pend_q    <= 1'b0;
      rd_owner_q   <= 1'b0;
    end else begin
      last_grant_q <= last_grant_d;
      rd_pend_q    <= rd_pend_d;
      rd_owner_q   <= rd_owner_d;
    end
  end
endmodule

// File: tb/tb_nios_onchip_mem_arbiter.sv
// Bench for the on-chip RAM arbiter: directed scenarios plus randomized traffic vs. a transaction model.
module tb_nios_onchip_mem_arbiter;
  import nios_memarb_pkg::*;

  logic clk = 1'b0, reset = 1'b1, freeze = 1'b0;
  always #5 clk = ~clk;

  nios_memarb_avm_if m0_if ();
  nios_memarb_avm_if m1_if ();
  nios_memarb_mem_if mem_if ();

  nios_onchip_mem_arbiter dut (
    .clk    (clk),
    .reset  (reset),
    .freeze (freeze),
    .m0     (m0_if),
    .m1     (m1_if),
    .mem    (mem_if)
  );

  // RAM: registered address, unregistered q, everything gated by clken.
  logic [31:0] ram [4] = '{32'h0, 32'h01010101, 32'h02020202, 32'h03030303};
  logic [1:0]  ram_aq = 2'd0;
  always @(posedge clk) begin
    if (mem_if.clken) begin
      ram_aq <= mem_if.address;
      if (mem_if.chipselect && mem_if.write)
        for (int b = 0; b < 4; b++)
          if (mem_if.byteenable[b]) ram[mem_if.address][b*8 +: 8] <= mem_if.writedata[b*8 +: 8];
    end
  end
  assign mem_if.readdata = ram[ram_aq];

  int vec = 0, errs = 0;

  // Transaction-level reference: who wins, what memory holds, which read is owed.
  int          mdl_last = 1;
  logic [31:0] mdl_mem [4];
  bit          mdl_pend = 0;
  int          mdl_owner = 0;
  logic [31:0] mdl_data = '0;
  int          e_win;
  bit          e_rdv0, e_rdv1;

  task automatic model_eval();
    bit a0, a1;
    a0 = m0_if.read || m0_if.write;
    a1 = m1_if.read || m1_if.write;
    if (reset || freeze) e_win = -1;
    else if (a0 && a1)   e_win = (mdl_last == 0) ? 1 : 0;
    else if (a0)         e_win = 0;
    else if (a1)         e_win = 1;
    else                 e_win = -1;
    e_rdv0 = mdl_pend && mdl_owner == 0 && !freeze && !reset;
    e_rdv1 = mdl_pend && mdl_owner == 1 && !freeze && !reset;
  endtask

  task automatic model_commit();
    logic [1:0] a; logic [3:0] be; logic [31:0] d; bit rd, wr;
    model_eval();
    if (reset) begin
      mdl_last = 1; mdl_pend = 0;
    end else if (!freeze) begin
      mdl_pend = 0;
      if (e_win >= 0) begin
        a  = (e_win == 1) ? m1_if.address    : m0_if.address;
        be = (e_win == 1) ? m1_if.byteenable : m0_if.byteenable;
        d  = (e_win == 1) ? m1_if.writedata  : m0_if.writedata;
        rd = (e_win == 1) ? m1_if.read       : m0_if.read;
        wr = (e_win == 1) ? m1_if.write      : m0_if.write;
        if (wr) begin
          for (int b = 0; b < 4; b++) if (be[b]) mdl_mem[a][b*8 +: 8] = d[b*8 +: 8];
        end else if (rd) begin
          mdl_pend = 1; mdl_owner = e_win; mdl_data = mdl_mem[a];
        end
        mdl_last = e_win;
      end
    end
  endtask

  task automatic drive(input int n, input bit rd, input bit wr, input logic [1:0] a,
                       input logic [3:0] be, input logic [31:0] d);
    if (n == 0) begin
      m0_if.read = rd; m0_if.write = wr; m0_if.address = a; m0_if.byteenable = be; m0_if.writedata = d;
    end else begin
      m1_if.read = rd; m1_if.write = wr; m1_if.address = a; m1_if.byteenable = be; m1_if.writedata = d;
    end
  endtask

  task automatic idle();
    drive(0, 0, 0, 2'd0, 4'h0, 32'h0);
    drive(1, 0, 0, 2'd0, 4'h0, 32'h0);
  endtask

  task automatic settle();
    #1; model_eval();
  endtask

  task automatic adv();
    @(posedge clk); model_commit(); @(negedge clk);
  endtask

  task automatic test_reset();
    reset = 1'b1;
    drive(0, 1, 0, 2'd1, 4'hF, 32'h0);
    drive(1, 1, 0, 2'd2, 4'hF, 32'h0);
    settle();
    vec++; if (m0_if.waitrequest !== 1'b1) begin errs++; $display("FAIL rst_wait0 got %b exp 1", m0_if.waitrequest); end
    vec++; if (m1_if.waitrequest !== 1'b1) begin errs++; $display("FAIL rst_wait1 got %b exp 1", m1_if.waitrequest); end
    vec++; if (mem_if.chipselect !== 1'b0) begin errs++; $display("FAIL rst_cs got %b exp 0", mem_if.chipselect); end
    vec++; if (mem_if.write !== 1'b0) begin errs++; $display("FAIL rst_write got %b exp 0", mem_if.write); end
    vec++; if (mem_if.clken !== 1'b1) begin errs++; $display("FAIL rst_clken got %b exp 1", mem_if.clken); end
    adv();
    reset = 1'b0; idle(); settle();
    vec++; if (m0_if.readdatavalid !== 1'b0) begin errs++; $display("FAIL rst_rdv0 got %b exp 0", m0_if.readdatavalid); end
    vec++; if (m1_if.readdatavalid !== 1'b0) begin errs++; $display("FAIL rst_rdv1 got %b exp 0", m1_if.readdatavalid); end
  endtask

  task automatic test_write_read();
    drive(0, 0, 1, 2'd2, 4'hF, 32'hDEADBEEF); settle();
    vec++; if (m0_if.waitrequest !== 1'b0) begin errs++; $display("FAIL wr_wait0 got %b exp 0", m0_if.waitrequest); end
    vec++; if (mem_if.write !== 1'b1) begin errs++; $display("FAIL wr_memwrite got %b exp 1", mem_if.write); end
    adv();
    drive(0, 1, 0, 2'd2, 4'hF, 32'h0); settle();
    vec++; if (m0_if.waitrequest !== 1'b0) begin errs++; $display("FAIL rd_wait0 got %b exp 0", m0_if.waitrequest); end
    adv();
    idle(); settle();
    vec++; if (m0_if.readdatavalid !== 1'b1) begin errs++; $display("FAIL rd_rdv0 got %b exp 1", m0_if.readdatavalid); end
    vec++; if (m0_if.readdata !== 32'hDEADBEEF) begin errs++; $display("FAIL rd_data got %h exp deadbeef", m0_if.readdata); end
    vec++; if (m1_if.readdatavalid !== 1'b0) begin errs++; $display("FAIL rd_rdv1 got %b exp 0", m1_if.readdatavalid); end
    adv();
  endtask

  task automatic test_byteenable();
    drive(1, 0, 1, 2'd1, 4'hF, 32'h11223344); settle(); adv();
    drive(1, 0, 1, 2'd1, 4'h1, 32'h000000AA); settle();
    vec++; if (mem_if.byteenable !== 4'h1) begin errs++; $display("FAIL be_pins got %h exp 1", mem_if.byteenable); end
    adv();
    drive(1, 1, 0, 2'd1, 4'hF, 32'h0); settle(); adv();
    idle(); settle();
    vec++; if (m1_if.readdatavalid !== 1'b1) begin errs++; $display("FAIL be_rdv1 got %b exp 1", m1_if.readdatavalid); end
    vec++; if (m1_if.readdata !== 32'h112233AA) begin errs++; $display("FAIL be_data got %h exp 112233aa", m1_if.readdata); end
    adv();
  endtask

  task automatic test_contention();
    bit w;
    reset = 1'b1; idle(); settle(); adv();
    reset = 1'b0;
    drive(0, 1, 0, 2'd2, 4'hF, 32'h0);
    drive(1, 1, 0, 2'd1, 4'hF, 32'h0);
    for (int i = 0; i < 8; i++) begin
      settle();
      w = (i % 2) != 0;
      vec++; if (m0_if.waitrequest !== w) begin errs++; $display("FAIL rr_wait0[%0d] got %b exp %b", i, m0_if.waitrequest, w); end
      vec++; if (m1_if.waitrequest !== !w) begin errs++; $display("FAIL rr_wait1[%0d] got %b exp %b", i, m1_if.waitrequest, !w); end
      if (i > 0) begin
        vec++; if (m0_if.readdatavalid !== w) begin errs++; $display("FAIL rr_rdv0[%0d] got %b exp %b", i, m0_if.readdatavalid, w); end
        vec++; if (m1_if.readdatavalid !== !w) begin errs++; $display("FAIL rr_rdv1[%0d] got %b exp %b", i, m1_if.readdatavalid, !w); end
        vec++; if (m0_if.readdata !== (w ? 32'hDEADBEEF : 32'h112233AA)) begin errs++; $display("FAIL rr_data[%0d] got %h", i, m0_if.readdata); end
      end
      adv();
    end
    idle(); settle();
    vec++; if (m1_if.readdatavalid !== 1'b1) begin errs++; $display("FAIL rr_last_rdv1 got %b exp 1", m1_if.readdatavalid); end
    adv();
  endtask

  task automatic test_freeze();
    drive(0, 1, 0, 2'd2, 4'hF, 32'h0); settle(); adv();
    drive(0, 0, 0, 2'd0, 4'h0, 32'h0);
    drive(1, 1, 0, 2'd1, 4'hF, 32'h0);
    freeze = 1'b1;
    for (int i = 0; i < 3; i++) begin
      settle();
      vec++; if (mem_if.clken !== 1'b0) begin errs++; $display("FAIL frz_clken[%0d] got %b exp 0", i, mem_if.clken); end
      vec++; if (m0_if.waitrequest !== 1'b1 || m1_if.waitrequest !== 1'b1) begin errs++; $display("FAIL frz_wait[%0d] got %b%b exp 11", i, m0_if.waitrequest, m1_if.waitrequest); end
      vec++; if (m0_if.readdatavalid !== 1'b0) begin errs++; $display("FAIL frz_rdv0[%0d] got %b exp 0", i, m0_if.readdatavalid); end
      adv();
    end
    freeze = 1'b0; settle();
    vec++; if (m0_if.readdatavalid !== 1'b1) begin errs++; $display("FAIL thaw_rdv0 got %b exp 1", m0_if.readdatavalid); end
    vec++; if (m0_if.readdata !== 32'hDEADBEEF) begin errs++; $display("FAIL thaw_data got %h exp deadbeef", m0_if.readdata); end
    vec++; if (m1_if.waitrequest !== 1'b0) begin errs++; $display("FAIL thaw_wait1 got %b exp 0", m1_if.waitrequest); end
    adv();
    idle(); settle();
    vec++; if (m1_if.readdatavalid !== 1'b1 || m1_if.readdata !== 32'h112233AA) begin errs++; $display("FAIL thaw_m1 got %b/%h exp 1/112233aa", m1_if.readdatavalid, m1_if.readdata); end
    adv();
  endtask

  task automatic test_reset_drop();
    drive(1, 1, 0, 2'd0, 4'hF, 32'h0); settle();
    vec++; if (m1_if.waitrequest !== 1'b0) begin errs++; $display("FAIL drop_wait1 got %b exp 0", m1_if.waitrequest); end
    adv();
    idle(); reset = 1'b1; settle();
    vec++; if (m1_if.readdatavalid !== 1'b0) begin errs++; $display("FAIL drop_rdv1_rst got %b exp 0", m1_if.readdatavalid); end
    adv();
    reset = 1'b0;
    drive(0, 1, 0, 2'd2, 4'hF, 32'h0);
    drive(1, 1, 0, 2'd1, 4'hF, 32'h0);
    settle();
    vec++; if (m1_if.readdatavalid !== 1'b0) begin errs++; $display("FAIL drop_rdv1_after got %b exp 0", m1_if.readdatavalid); end
    vec++; if (m0_if.waitrequest !== 1'b0 || m1_if.waitrequest !== 1'b1) begin errs++; $display("FAIL drop_grant got %b%b exp 01", m0_if.waitrequest, m1_if.waitrequest); end
    adv();
    idle(); settle();
    vec++; if (m0_if.readdatavalid !== 1'b1 || m1_if.readdatavalid !== 1'b0) begin errs++; $display("FAIL drop_rdv got %b%b exp 10", m0_if.readdatavalid, m1_if.readdatavalid); end
    adv();
  endtask

  task automatic test_rw_both();
    drive(0, 1, 1, 2'd3, 4'hF, 32'h5); settle();
    vec++; if (m0_if.waitrequest !== 1'b0 || mem_if.write !== 1'b1) begin errs++; $display("FAIL rw_accept got wait %b write %b exp 0 1", m0_if.waitrequest, mem_if.write); end
    adv();
    idle(); settle();
    vec++; if (m0_if.readdatavalid !== 1'b0) begin errs++; $display("FAIL rw_rdv0 got %b exp 0", m0_if.readdatavalid); end
    adv();
    drive(0, 1, 0, 2'd3, 4'hF, 32'h0); settle(); adv();
    idle(); settle();
    vec++; if (m0_if.readdatavalid !== 1'b1 || m0_if.readdata !== 32'h5) begin errs++; $display("FAIL rw_readback got %b/%h exp 1/00000005", m0_if.readdatavalid, m0_if.readdata); end
    adv();
  endtask

  task automatic test_random();
    bit hold0 = 0, hold1 = 0, rd, wr;
    for (int c = 0; c < 400; c++) begin
      reset  = ($urandom_range(0, 49) == 0);
      freeze = ($urandom_range(0, 6) == 0);
      for (int n = 0; n < 2; n++) begin
        if ((n == 0 && !hold0) || (n == 1 && !hold1)) begin
          int op;
          op = $urandom_range(0, 5);
          rd = (op == 1 || op == 2 || op == 5);
          wr = (op == 3 || op == 4 || op == 5);
          drive(n, rd, wr, 2'($urandom_range(0, 3)), 4'($urandom_range(0, 15)), $urandom);
        end
      end
      settle();
      vec++; if (m0_if.waitrequest !== (e_win != 0)) begin errs++; $display("FAIL rnd_wait0[%0d] got %b", c, m0_if.waitrequest); end
      vec++; if (m1_if.waitrequest !== (e_win != 1)) begin errs++; $display("FAIL rnd_wait1[%0d] got %b", c, m1_if.waitrequest); end
      vec++; if (mem_if.chipselect !== (e_win >= 0)) begin errs++; $display("FAIL rnd_cs[%0d] got %b", c, mem_if.chipselect); end
      vec++; if (mem_if.clken !== (reset || !freeze)) begin errs++; $display("FAIL rnd_clken[%0d] got %b", c, mem_if.clken); end
      vec++; if (m0_if.readdatavalid !== e_rdv0 || m1_if.readdatavalid !== e_rdv1) begin errs++; $display("FAIL rnd_rdv[%0d] got %b%b exp %b%b", c, m0_if.readdatavalid, m1_if.readdatavalid, e_rdv0, e_rdv1); end
      if (e_rdv0 || e_rdv1) begin
        vec++; if (m0_if.readdata !== mdl_data) begin errs++; $display("FAIL rnd_data[%0d] got %h exp %h", c, m0_if.readdata, mdl_data); end
      end
      // A refused requester keeps its request asserted unchanged.
      hold0 = (m0_if.read || m0_if.write) && e_win != 0;
      hold1 = (m1_if.read || m1_if.write) && e_win != 1;
      adv();
    end
    reset = 1'b0; freeze = 1'b0; idle();
  endtask

  initial begin
    for (int i = 0; i < 4; i++) mdl_mem[i] = 32'h01010101 * i;
    idle();
    @(negedge clk);
    test_reset();
    test_write_read();
    test_byteenable();
    test_contention();
    test_freeze();
    test_reset_drop();
    test_rw_both();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", vec, errs);
    $finish;
  end
endmodule
